alu_4bit_bist: RTL and testbench
================================

// Module: alu_4bit_bist
// PURPOSE
//  Built-in self-test controller for the 4-bit ALU (advanced_alu_4bit).
//  Drives the ALU operand/opcode inputs and reads back result/carry_out.
//  Sweeps every {op_code, a, b} combination and checks each response against
//  an internal reference model.
//  Reports pass/fail, the error count and the first failing vector.
// PARAMETERS
//  WIDTH   4  operand width; vector space = 2^(2*WIDTH+2) = 1024
//  SETTLE  1  cycles each vector is held before sampling (>=1)
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous, active-high reset
//  start        in   1        begin sweep; sampled in IDLE/DONE only
//  alu_a        out  WIDTH    ALU operand a (registered)
//  alu_b        out  WIDTH    ALU operand b (registered)
//  alu_op       out  2        ALU op_code: 00 ADD, 01 SUB, 10 AND, 11 OR
//  alu_result   in   WIDTH    ALU result
//  alu_carry    in   1        ALU carry_out
//  busy         out  1        sweep in progress
//  done         out  1        sweep complete; held until next start or rst
//  pass         out  1        valid when done=1: err_count==0
//  err_count    out  2W+3     mismatching vectors in this sweep (11b, max 1024)
//  fail_valid   out  1        at least one mismatch captured
//  fail_vec     out  2W+2     {op,a,b} of first mismatch
//  fail_result  out  WIDTH    alu_result observed at first mismatch
//  fail_carry   out  1        alu_carry observed at first mismatch
// BEHAVIOUR
//  - Reset: all outputs 0, vector index 0, state IDLE. rst overrides start.
//    rst mid-sweep aborts: next cycle IDLE, all counters/captures cleared.
//  - Vector index vec[2W+1:0] = {op,a,b}; b fastest. Runs 0..1023, no wrap.
//  - FSM IDLE -> APPLY -> CHECK -> (APPLY | DONE); DONE -> APPLY on start.
//  - IDLE/DONE + start: clears err_count, fail_* and done. Loads vec=0 onto
//    alu_* outputs. Enters APPLY with busy=1 next cycle.
//  - APPLY: hold alu_* for SETTLE cycles (settle counter), then go to CHECK.
//  - CHECK: compare alu_result/alu_carry with the model. On mismatch,
//    err_count+1; if fail_valid=0, capture fail_* and set fail_valid.
//    If vec==1023, go to DONE. Otherwise vec+1, alu_* updated, go to APPLY.
//  - start while busy is ignored.
//  - Reference model (WIDTH-bit, mod 2^WIDTH):
//    ADD: res=a+b, carry = bit WIDTH of (a+b).
//    SUB: res=a-b, carry = NOT borrow (1 iff a>=b).
//    AND/OR: res=a&b / a|b; carry not checked.
//  - Mismatch = result differs, or carry differs on ADD/SUB.
//  - Timing: start seen in cycle T -> last CHECK at T+1024*(SETTLE+1).
//    done=1, busy=0, pass valid at T+1024*(SETTLE+1)+1.
//  - alu_* keep the last vector in DONE. busy and done are never both 1.
// TESTING (SETTLE=1, golden ALU unless noted)
//  1 Golden ALU, start at T -> done at T+2049; pass=1, err_count=0,
//    fail_valid=0. Spot checks: 7+3 -> 10 c0; 7-3 -> 4 c1;
//    7&3 -> 3; 15+1 -> 0 c1.
//  2 AND result bit0 forced 0 -> err_count=64, pass=0,
//    fail_vec=0x211, fail_result=0000.
//  3 SUB carry inverted -> err_count=256, fail_vec=0x100,
//    fail_result=0000, fail_carry=0.
//  4 AND/OR carry forced 1 -> pass=1 (carry ignored on logic ops).
//  5 rst pulsed at vector 300 -> next cycle busy=0, err_count=0, alu_*=0.
//    Restart completes a full 2049-cycle sweep.
//  6 start pulsed while busy -> no effect on timing. start again in DONE
//    -> counters cleared, new sweep begins.

Source files
------------

// File: rtl/alu_4bit_bist.sv
// Self-test sequencer for the 4-bit ALU: sweeps every {op,a,b} vector,
// compares each response with a reference model, and keeps the first failure.
module alu_4bit_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [1:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carry,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+2:0]   err_count,
  output logic                 fail_valid,
  output logic [2*WIDTH+1:0]   fail_vec,
  output logic [WIDTH-1:0]     fail_result,
  output logic                 fail_carry
);

  localparam int VW = 2*WIDTH + 2;
  localparam int EW = VW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [VW-1:0] LAST = '1;
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [VW-1:0]    r_vec;
  logic [EW-1:0]    r_err;
  logic             r_fvalid;
  logic [VW-1:0]    r_fvec;
  logic [WIDTH-1:0] r_fres;
  logic             r_fcar;
  logic [SW-1:0]    r_settle;

  logic             w_start_ok;
  logic             w_settled;
  logic             w_last;
  logic             w_check;
  logic             w_mismatch;

  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_exp_res;
  logic             w_exp_car;
  logic             w_chk_car;

  assign w_op = r_vec[VW-1:2*WIDTH];
  assign w_a  = r_vec[2*WIDTH-1:WIDTH];
  assign w_b  = r_vec[WIDTH-1:0];

  assign w_start_ok = start &&
    (r_state == S_IDLE || r_state == S_DONE);
  assign w_settled = (r_settle == SETTLE_END);
  assign w_last    = (r_vec == LAST);
  assign w_check   = (r_state == S_CHECK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_APPLY;
      S_DONE:  if (start) w_next = S_APPLY;
      S_APPLY: if (w_settled) w_next = S_CHECK;
      S_CHECK: w_next = w_last ? S_DONE : S_APPLY;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    unique case (r_state)
      S_APPLY: busy = 1'b1;
      S_CHECK: busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        pass = (r_err == '0);
      end
      default: ;
    endcase
  end

  // Reference model; carry is only meaningful for arithmetic ops
  always_comb begin
    w_sum     = {1'b0, w_a} + {1'b0, w_b};
    w_dif     = {1'b0, w_a} - {1'b0, w_b};
    w_exp_res = '0;
    w_exp_car = 1'b0;
    w_chk_car = 1'b0;
    unique case (w_op)
      2'b00: begin
        w_exp_res = w_sum[WIDTH-1:0];
        w_exp_car = w_sum[WIDTH];
        w_chk_car = 1'b1;
      end
      2'b01: begin
        w_exp_res = w_dif[WIDTH-1:0];
        w_exp_car = ~w_dif[WIDTH];
        w_chk_car = 1'b1;
      end
      2'b10: w_exp_res = w_a & w_b;
      2'b11: w_exp_res = w_a | w_b;
      default: ;
    endcase
  end

  assign w_mismatch = (alu_result != w_exp_res) ||
    (w_chk_car && (alu_carry != w_exp_car));

  always_ff @(posedge clk) begin
    if (rst || r_state != S_APPLY || w_settled)
      r_settle <= '0;
    else
      r_settle <= r_settle + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec    <= '0;
      r_err    <= '0;
      r_fvalid <= 1'b0;
      r_fvec   <= '0;
      r_fres   <= '0;
      r_fcar   <= 1'b0;
    end else if (w_start_ok) begin
      r_vec    <= '0;
      r_err    <= '0;
      r_fvalid <= 1'b0;
      r_fvec   <= '0;
      r_fres   <= '0;
      r_fcar   <= 1'b0;
    end else if (w_check) begin
      if (w_mismatch) begin
        r_err <= r_err + EW'(1);
        if (!r_fvalid) begin
          r_fvalid <= 1'b1;
          r_fvec   <= r_vec;
          r_fres   <= alu_result;
          r_fcar   <= alu_carry;
        end
      end
      // Last vector stays on the ALU pins in DONE
      if (!w_last) r_vec <= r_vec + VW'(1);
    end
  end

  assign alu_op      = w_op;
  assign alu_a       = w_a;
  assign alu_b       = w_b;
  assign err_count   = r_err;
  assign fail_valid  = r_fvalid;
  assign fail_vec    = r_fvec;
  assign fail_result = r_fres;
  assign fail_carry  = r_fcar;

endmodule

// File: tb/tb_alu_4bit_bist.sv
// Bench for alu_4bit_bist: behavioural ALU with selectable faults,
// table of full sweeps plus reset-abort and start-while-busy sequences.
module tb_alu_4bit_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       busy;
  logic       done;
  logic       pass;
  logic [10:0] err_count;
  logic       fail_valid;
  logic [9:0] fail_vec;
  logic [3:0] fail_result;
  logic       fail_carry;

  int fault;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_4bit_bist #(.WIDTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid),
    .fail_vec(fail_vec), .fail_result(fail_result),
    .fail_carry(fail_carry)
  );

  // Behavioural ALU with injectable faults
  logic [4:0] m_sum;
  logic [4:0] m_dif;
  always_comb begin
    m_sum = {1'b0, alu_a} + {1'b0, alu_b};
    m_dif = {1'b0, alu_a} - {1'b0, alu_b};
    alu_result = 4'h0;
    alu_carry  = 1'b0;
    case (alu_op)
      2'b00: begin alu_result = m_sum[3:0]; alu_carry = m_sum[4]; end
      2'b01: begin alu_result = m_dif[3:0]; alu_carry = ~m_dif[4]; end
      2'b10: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
    case (fault)
      1: if (alu_op == 2'b10) alu_result[0] = 1'b0;
      2: if (alu_op == 2'b01) alu_carry = ~alu_carry;
      3: if (alu_op[1]) alu_carry = 1'b1;
      4: if (alu_op == 2'b00 && alu_a == 4'hF && alu_b == 4'h1)
           alu_result = alu_result ^ 4'h1;
      5: if (alu_op == 2'b00 && alu_a == 4'h7 && alu_b == 4'h3)
           alu_carry = ~alu_carry;
      6: if (alu_op == 2'b11) alu_result[3] = 1'b1;
      default: ;
    endcase
  end

  typedef struct {
    int         fault;
    int         err;
    logic       pass;
    logic       fv;
    logic [9:0] fvec;
    logic [3:0] fres;
    logic       fcar;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Start a sweep and wait for done; returns cycles from start to done
  task automatic run_sweep(input bit poke_mid, output int cycles);
    int  n;
    bit  both;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    n = 0;
    both = 0;
    cycles = 0;
    while (n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      if (busy && done) both = 1;
      start = (poke_mid && n == 500);
      if (done) break;
    end
    start = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL sweep_timeout: done=0 after %0d cycles", n);
    end
    cycles = n + 1;
    chk("busy_done_exclusive", both, 0);
  endtask

  initial begin
    int cyc;
    int n;
    tbl[0] = '{0,   0, 1'b1, 1'b0, 10'h000, 4'h0, 1'b0};
    tbl[1] = '{1,  64, 1'b0, 1'b1, 10'h211, 4'h0, 1'b0};
    tbl[2] = '{2, 256, 1'b0, 1'b1, 10'h100, 4'h0, 1'b0};
    tbl[3] = '{3,   0, 1'b1, 1'b0, 10'h000, 4'h0, 1'b0};
    tbl[4] = '{4,   1, 1'b0, 1'b1, 10'h0F1, 4'h1, 1'b1};
    tbl[5] = '{5,   1, 1'b0, 1'b1, 10'h073, 4'hA, 1'b1};
    tbl[6] = '{6,  64, 1'b0, 1'b1, 10'h300, 4'h8, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    fault = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fv", fail_valid, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_start", busy, 0);
    start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fault = tbl[i].fault;
      run_sweep(1'b0, cyc);
      chk($sformatf("t%0d_cycles", i), cyc, 2049);
      chk($sformatf("t%0d_busy", i), busy, 0);
      chk($sformatf("t%0d_pass", i), pass, tbl[i].pass);
      chk($sformatf("t%0d_err", i), err_count, tbl[i].err);
      chk($sformatf("t%0d_fv", i), fail_valid, tbl[i].fv);
      chk($sformatf("t%0d_fvec", i), fail_vec, tbl[i].fvec);
      chk($sformatf("t%0d_fres", i), fail_result, tbl[i].fres);
      chk($sformatf("t%0d_fcar", i), fail_carry, tbl[i].fcar);
      chk($sformatf("t%0d_last_vec", i), {alu_op, alu_a, alu_b}, 1023);
    end

    // Reset abort at vector 300 with SUB carry fault active
    fault = 2;
    pulse_start();
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      if ({alu_op, alu_a, alu_b} == 10'd300) break;
    end
    chk("reach_vec300", {alu_op, alu_a, alu_b}, 300);
    chk("err_at_300", err_count, 44);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err_count, 0);
    chk("abort_fv", fail_valid, 0);
    chk("abort_alu", {alu_op, alu_a, alu_b}, 0);
    fault = 0;
    run_sweep(1'b0, cyc);
    chk("restart_cycles", cyc, 2049);
    chk("restart_pass", pass, 1);

    // start while busy must not disturb the sweep
    run_sweep(1'b1, cyc);
    chk("midstart_cycles", cyc, 2049);
    chk("midstart_pass", pass, 1);
    chk("midstart_err", err_count, 0);

    // start again from DONE with a fault: fresh counters
    fault = 1;
    run_sweep(1'b0, cyc);
    chk("again_cycles", cyc, 2049);
    chk("again_err", err_count, 64);
    chk("again_fvec", fail_vec, 10'h211);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
